// File: rtl/demuxn_collect_pkg.sv
// Shared definitions for the serial-to-word collector: FSM state encoding
// and the word-width helper used by the top and the slot decoder.
package demuxn_collect_pkg;

    // FILL: collecting bits; HOLD: complete word presented to the consumer.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Output word width for a given number of selector bits.
    function automatic int unsigned word_w(input int unsigned nb_sel);
        return 32'd1 << nb_sel;
    endfunction

endpackage

// File: rtl/demuxn_collect_decodern.sv
// Binary-to-one-hot decoder with enable. With en_i low every output is
// low, so a single instance can gate both data and mask writes.
module decodern
    import demuxn_collect_pkg::*;
#(
    parameter int NB_SEL = 3
) (
    input  logic                        en_i,
    input  logic [NB_SEL-1:0]           sel_i,
    output logic [word_w(NB_SEL)-1:0]   onehot_o
);

    // Raise exactly one output bit when enabled, none otherwise.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demuxn_collect.sv
// Registered 1-to-N demultiplexer that assembles a 2**NB_SEL-bit word from
// single bits, addressed either by an internal auto-incrementing pointer or
// by an explicit selector. Once every slot has been written the word is
// held and offered to the consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are pure decodes of the registered
// state, so neither depends combinationally on any input. A producer may
// hold in_valid while in_ready is low; the bit is simply not taken. Once
// out_valid rises it stays high until an edge with out_ready=1 (or flush).
module demuxn_collect
    import demuxn_collect_pkg::*;
#(
    parameter int NB_SEL = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        dir_mode,
    input  logic [NB_SEL-1:0]           sel,
    input  logic                        flush,
    output logic [word_w(NB_SEL)-1:0]   outs,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NB_SEL-1:0]           ptr
);

    localparam int W = word_w(NB_SEL);
    localparam logic [NB_SEL-1:0] PTR_ONE = {{(NB_SEL-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [W-1:0]      outs_q, outs_d;
    logic [W-1:0]      mask_q, mask_d;
    logic [NB_SEL-1:0] ptr_q, ptr_d;

    logic              accept;
    logic [NB_SEL-1:0] slot;
    logic [W-1:0]      wr_en;

    // Flush wins over accept, so a bit arriving with flush is dropped.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready && !flush;
    assign slot      = dir_mode ? sel : ptr_q;

    decodern #(
        .NB_SEL (NB_SEL)
    ) u_slot_dec (
        .en_i     (accept),
        .sel_i    (slot),
        .onehot_o (wr_en)
    );

    // Next-state: flush, then release in HOLD, then bit accept in FILL.
    always_comb begin
        state_d = state_q;
        outs_d  = outs_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        if (flush) begin
            state_d = FILL;
            outs_d  = '0;
            mask_d  = '0;
            ptr_d   = '0;
        end else if (state_q == HOLD) begin
            if (out_ready) begin
                state_d = FILL;
                outs_d  = '0;
                mask_d  = '0;
                ptr_d   = '0;
            end
        end else begin
            outs_d = (outs_q & ~wr_en) | (wr_en & {W{in}});
            mask_d = mask_q | wr_en;
            if (accept && !dir_mode) begin
                ptr_d = ptr_q + PTR_ONE;
            end
            if (&mask_d) begin
                state_d = HOLD;
            end
        end
    end

    // State, word, written-mask and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            outs_q  <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
        end
    end

    assign outs = outs_q;
    assign ptr  = ptr_q;

endmodule

// File: tb/tb_demuxn_collect.sv
// Bench for demuxn_collect (NB_SEL=3): directed vector table, async reset
// sequences, then randomized traffic checked against a word-level model.
module tb_demuxn_collect;

    localparam int NB = 3;
    localparam int W  = 8;

    logic          clk;
    logic          rst_n;
    logic          din;
    logic          in_valid;
    logic          in_ready;
    logic          dir_mode;
    logic [NB-1:0] sel;
    logic          flush;
    logic [W-1:0]  outs;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] ptr;

    int n_vec;
    int n_err;

    demuxn_collect #(.NB_SEL(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dir_mode  (dir_mode),
        .sel       (sel),
        .flush     (flush),
        .outs      (outs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ptr       (ptr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic          d;
        logic          dm;
        logic [NB-1:0] s;
        logic          fl;
        logic          ordy;
        logic [W-1:0]  e_outs;
        logic          e_ov;
        logic          e_ir;
        logic [NB-1:0] e_ptr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic d, input logic dm,
                                input logic [NB-1:0] s, input logic fl, input logic ordy,
                                input logic [W-1:0] e_outs, input logic e_ov,
                                input logic [NB-1:0] e_ptr);
        vec_t v;
        v.iv = iv; v.d = d; v.dm = dm; v.s = s; v.fl = fl; v.ordy = ordy;
        v.e_outs = e_outs; v.e_ov = e_ov; v.e_ir = ~e_ov; v.e_ptr = e_ptr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] e_outs, input logic e_ov,
                           input logic e_ir, input logic [NB-1:0] e_ptr);
        chk({tag, ".outs"}, outs, e_outs);
        chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e_ov});
        chk({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, e_ir});
        chk({tag, ".ptr"}, {5'd0, ptr}, {5'd0, e_ptr});
    endtask

    task automatic drive(input logic iv, input logic d, input logic dm,
                         input logic [NB-1:0] s, input logic fl, input logic ordy);
        in_valid = iv; din = d; dir_mode = dm; sel = s; flush = fl; out_ready = ordy;
    endtask

    // Apply inputs now, then sample #1 after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word-level reference model
    bit m_word[W];
    bit m_mask[W];
    int m_ptr;
    bit m_hold;

    function automatic void m_clear();
        for (int i = 0; i < W; i++) begin
            m_word[i] = 1'b0;
            m_mask[i] = 1'b0;
        end
        m_ptr  = 0;
        m_hold = 1'b0;
    endfunction

    function automatic logic [W-1:0] m_pack();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = m_word[i];
        return r;
    endfunction

    function automatic void m_edge(input bit iv, input bit d, input bit dm,
                                   input int s, input bit fl, input bit ordy);
        int filled;
        int slot;
        if (fl) begin
            m_clear();
        end else if (m_hold) begin
            if (ordy) m_clear();
        end else if (iv) begin
            slot = dm ? s : m_ptr;
            m_word[slot] = d;
            m_mask[slot] = 1'b1;
            if (!dm) m_ptr = (m_ptr + 1) % W;
            filled = 0;
            for (int i = 0; i < W; i++) filled += m_mask[i];
            if (filled == W) m_hold = 1'b1;
        end
    endfunction

    initial begin
        logic [7:0] pat;
        n_vec = 0;
        n_err = 0;

        // Table: auto fill of 1,0,1,1,0,0,1,0 (slot0 first)
        pat = 8'b0100_1101;
        begin
            logic [W-1:0] acc;
            acc = '0;
            for (int i = 0; i < W; i++) begin
                acc[i] = pat[i];
                vecs.push_back(mk(1, pat[i], 0, 0, 0, 0, acc, i == W-1, NB'((i + 1) % W)));
            end
        end
        // Backpressure: input offered while holding, word must stay put
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h4D, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 0, 0));
        // Direct addressing with overwrite of slot 7
        vecs.push_back(mk(1, 1, 1, 7, 0, 0, 8'h80, 0, 0));
        vecs.push_back(mk(1, 0, 1, 7, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 8'h03, 0, 0));
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 8'h07, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 8'h0F, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4, 0, 0, 8'h1F, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5, 0, 0, 8'h3F, 0, 0));
        vecs.push_back(mk(1, 1, 1, 6, 0, 0, 8'h7F, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 0, 0));
        // Mixed mode: 3 auto, then direct 3..7; ptr parks at 3
        vecs.push_back(mk(1, 1, 0, 5, 0, 0, 8'h01, 0, 1));
        vecs.push_back(mk(1, 1, 0, 5, 0, 0, 8'h03, 0, 2));
        vecs.push_back(mk(1, 1, 0, 5, 0, 0, 8'h07, 0, 3));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 8'h0F, 0, 3));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 8'h0F, 0, 3));
        vecs.push_back(mk(1, 1, 1, 5, 0, 0, 8'h2F, 0, 3));
        vecs.push_back(mk(1, 0, 1, 6, 0, 0, 8'h2F, 0, 3));
        vecs.push_back(mk(1, 1, 1, 7, 0, 0, 8'hAF, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 0, 0));
        // Flush mid-word drops the coinciding bit; a full word is still needed
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h01, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h03, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h07, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h0F, 0, 4));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 8'h00, 0, 0));
        for (int i = 0; i < W; i++) begin
            vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'((16'h1 << (i + 1)) - 1), i == W-1, NB'((i + 1) % W)));
        end
        // Flush in HOLD beats the hold without any out_ready
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0));

        // Reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 0, 1, 0);
        #2 rst_n = 1'b1;
        #1 chk_all("post_reset", 8'h00, 0, 1, 0);
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].iv, vecs[i].d, vecs[i].dm, vecs[i].s, vecs[i].fl, vecs[i].ordy);
            step();
            chk_all(tag, vecs[i].e_outs, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_ptr);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Async reset mid-word, no clock edge while asserted or after release
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_all("pre_rst_word", 8'h07, 0, 1, 3);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_mid_word", 8'h00, 0, 1, 0);
        #1 rst_n = 1'b1;
        #1 chk_all("rel_mid_word", 8'h00, 0, 1, 0);
        step();

        // Async reset mid-HOLD
        for (int i = 0; i < W; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_all("pre_rst_hold", 8'hFF, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_mid_hold", 8'h00, 0, 1, 0);
        #1 rst_n = 1'b1;
        #1 chk_all("rel_mid_hold", 8'h00, 0, 1, 0);
        step();

        // Randomized traffic against the model
        m_clear();
        for (int c = 0; c < 400; c++) begin
            bit iv, d, dm, fl, ordy;
            int s;
            iv   = ($urandom_range(0, 3) != 0);
            d    = $urandom_range(0, 1);
            dm   = $urandom_range(0, 1);
            s    = $urandom_range(0, W-1);
            fl   = ($urandom_range(0, 24) == 0);
            ordy = ($urandom_range(0, 2) == 0);
            drive(iv, d, dm, NB'(s), fl, ordy);
            m_edge(iv, d, dm, s, fl, ordy);
            step();
            chk_all($sformatf("rnd%0d", c), m_pack(), m_hold, !m_hold, NB'(m_ptr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
